// File: rtl/wbus_reg_pkg.sv
// Shared constants for the WBUS register bank: micro-op codes,
// default geometry and bus drive levels.
package wbus_reg_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREG  = 4;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_INC = 3'd1;
  localparam logic [2:0] OP_DEC = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_CLR = 3'd5;

  localparam logic High_Impedance = 1'bz;
  localparam logic Zero_State     = 1'b0;

endpackage

// File: rtl/wbus_reg_file_if.sv
// Control/select/status bundle of the WBUS register bank.
// WBUS itself stays a plain inout net on the top module.
interface wbus_reg_file_if
  import wbus_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG
);
  localparam int SELW = $clog2(NREG);

  logic             nL;
  logic             E;
  logic [SELW-1:0]  wsel;
  logic [SELW-1:0]  rsel;
  logic [SELW-1:0]  asel;
  logic [2:0]       op;
  logic             op_v;
  logic [WIDTH-1:0] alu;
  logic             z;
  logic             cy;

  modport master (
    output nL, E, wsel, rsel, asel, op, op_v,
    input  alu, z, cy
  );

  modport slave (
    input  nL, E, wsel, rsel, asel, op, op_v,
    output alu, z, cy
  );
endinterface

// File: rtl/wbus_reg_alu.sv
// In-place micro-op unit: (r, op) -> next value, flags, change strobe.
// SHL/SHR exist only when WBUS_REG_SHIFT_EN is defined.
module wbus_reg_alu
  import wbus_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] r,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] nxt,
  output logic             cy_nxt,
  output logic             z_nxt,
  output logic             chg
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    nxt    = r;
    cy_nxt = 1'b0;
    chg    = 1'b0;
    unique case (1'b1)
      (op == OP_INC): begin
        nxt    = r + ONE;
        cy_nxt = &r;
        chg    = 1'b1;
      end
      (op == OP_DEC): begin
        nxt    = r - ONE;
        cy_nxt = ~|r;
        chg    = 1'b1;
      end
`ifdef WBUS_REG_SHIFT_EN
      (op == OP_SHL): begin
        nxt    = {r[WIDTH-2:0], 1'b0};
        cy_nxt = r[WIDTH-1];
        chg    = 1'b1;
      end
      (op == OP_SHR): begin
        nxt    = {1'b0, r[WIDTH-1:1]};
        cy_nxt = r[0];
        chg    = 1'b1;
      end
`endif
      (op == OP_CLR): begin
        nxt    = '0;
        cy_nxt = 1'b0;
        chg    = 1'b1;
      end
      default: ;
    endcase
  end

  assign z_nxt = (nxt == '0);

endmodule

// File: rtl/wbus_reg_file.sv
// NREG x WIDTH register bank on tri-state WBUS with INC/DEC/CLR micro-ops
// and registered z/cy; SHL/SHR added when WBUS_REG_SHIFT_EN is defined.
module wbus_reg_file
  import wbus_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG
) (
  input  logic             CLK,
  input  logic             nCLR,
  inout  wire  [WIDTH-1:0] WBUS,
  wbus_reg_file_if.slave   bus
);
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic             z_q, z_d;
  logic             cy_q, cy_d;

  logic             wr_ok;
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] alu_nxt;
  logic             alu_cy, alu_z, alu_chg;

  // Out-of-range selects (non power-of-two NREG) read as zero, write nothing
  assign wr_ok  = int'(bus.wsel) < NREG;
  assign wr_cur = wr_ok ? regs_q[bus.wsel] : '0;
  assign rd_val = (int'(bus.rsel) < NREG) ? regs_q[bus.rsel] : '0;

  assign bus.alu = (int'(bus.asel) < NREG) ? regs_q[bus.asel] : '0;
  assign bus.z   = z_q;
  assign bus.cy  = cy_q;

  assign WBUS = bus.E ? rd_val : {WIDTH{High_Impedance}};

  wbus_reg_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .r      (wr_cur),
    .op     (bus.op),
    .nxt    (alu_nxt),
    .cy_nxt (alu_cy),
    .z_nxt  (alu_z),
    .chg    (alu_chg)
  );

  // Load reads the resolved bus, so E with nL low is a one-cycle move
  always_comb begin
    regs_d = regs_q;
    z_d    = z_q;
    cy_d   = cy_q;
    if (wr_ok) begin
      if (!bus.nL) begin
        regs_d[bus.wsel] = WBUS;
        z_d              = (WBUS == {WIDTH{Zero_State}});
      end else if (bus.op_v && alu_chg) begin
        regs_d[bus.wsel] = alu_nxt;
        z_d              = alu_z;
        cy_d             = alu_cy;
      end
    end
  end

  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      z_q  <= 1'b0;
      cy_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      z_q    <= z_d;
      cy_q   <= cy_d;
    end
  end

endmodule

// File: tb/tb_wbus_reg_file.sv
// Self-checking bench for wbus_reg_file: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_wbus_reg_file;
  import wbus_reg_pkg::*;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int MOD = 1 << W;

  logic clk = 1'b0;
  logic nclr;
  always #10 clk = ~clk;

  logic [W-1:0] drv;
  logic         drv_en;
  wire  [W-1:0] WBUS;
  assign WBUS = drv_en ? drv : 'z;

  wbus_reg_file_if #(.WIDTH(W), .NREG(N)) bus ();

  wbus_reg_file #(
    .WIDTH (W),
    .NREG  (N)
  ) dut (
    .CLK  (clk),
    .nCLR (nclr),
    .WBUS (WBUS),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int m_reg [N];
  bit m_z;
  bit m_cy;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_reg[i] = 0;
    m_z  = 0;
    m_cy = 0;
  endtask

  // Applies the effect of the coming edge from the current inputs
  task automatic model_edge();
    int w;
    int v;
    w = int'(bus.wsel);
    if (!bus.nL) begin
      v = bus.E ? m_reg[int'(bus.rsel)] : int'(drv);
      m_reg[w] = v;
      m_z = (v == 0);
    end else if (bus.op_v) begin
      case (bus.op)
        OP_INC: begin
          m_cy = (m_reg[w] == MOD - 1);
          m_reg[w] = (m_reg[w] + 1) % MOD;
          m_z = (m_reg[w] == 0);
        end
        OP_DEC: begin
          m_cy = (m_reg[w] == 0);
          m_reg[w] = (m_reg[w] + MOD - 1) % MOD;
          m_z = (m_reg[w] == 0);
        end
`ifdef WBUS_REG_SHIFT_EN
        OP_SHL: begin
          m_cy = (m_reg[w] >= MOD / 2);
          m_reg[w] = (m_reg[w] * 2) % MOD;
          m_z = (m_reg[w] == 0);
        end
        OP_SHR: begin
          m_cy = (m_reg[w] % 2) == 1;
          m_reg[w] = m_reg[w] / 2;
          m_z = (m_reg[w] == 0);
        end
`endif
        OP_CLR: begin
          m_cy = 0;
          m_reg[w] = 0;
          m_z = 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic set_idle();
    bus.nL   = 1'b1;
    bus.E    = 1'b0;
    bus.op_v = 1'b0;
    bus.op   = OP_NOP;
    bus.wsel = '0;
    bus.rsel = '0;
    bus.asel = '0;
    drv_en   = 1'b0;
    drv      = '0;
  endtask

  task automatic clock_edge();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input int a, output logic [W-1:0] v);
    bus.asel = 2'(a);
    #1;
    v = bus.alu;
  endtask

  task automatic load(input int r, input int v);
    @(negedge clk);
    bus.nL   = 1'b0;
    bus.wsel = 2'(r);
    drv_en   = 1'b1;
    drv      = W'(v);
    clock_edge();
    set_idle();
  endtask

  task automatic do_op(input int r, input logic [2:0] code);
    @(negedge clk);
    bus.wsel = 2'(r);
    bus.op   = code;
    bus.op_v = 1'b1;
    clock_edge();
    set_idle();
  endtask

  task automatic test_reset();
    logic [W-1:0] v;
    nclr = 1'b1;
    #2 nclr = 1'b0;
    #5;
    model_reset();
    for (int i = 0; i < N; i++) begin
      peek(i, v);
      checks++;
      if (v !== '0) begin
        errors++;
        $display("FAIL reset_reg%0d: got %h exp 00", i, v);
      end
    end
    checks++;
    if (bus.z !== 1'b0 || bus.cy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got z=%b cy=%b exp 0 0", bus.z, bus.cy);
    end
    @(negedge clk);
    nclr = 1'b1;
  endtask

  task automatic test_load_bus();
    logic [W-1:0] v;
    load(2, 'h0A);
    peek(2, v);
    checks++;
    if (v !== 8'h0A || bus.z !== 1'b0) begin
      errors++;
      $display("FAIL load: got %h z=%b exp 0a z=0", v, bus.z);
    end
    bus.E = 1'b1;
    bus.rsel = 2'd2;
    #1;
    checks++;
    if (WBUS !== 8'h0A) begin
      errors++;
      $display("FAIL bus_drive: got %h exp 0a", WBUS);
    end
    // Block must stay off the bus while E is low
    bus.E  = 1'b0;
    drv    = 8'hA5;
    drv_en = 1'b1;
    #1;
    checks++;
    if (WBUS !== 8'hA5) begin
      errors++;
      $display("FAIL bus_release: got %h exp a5", WBUS);
    end
    set_idle();
  endtask

  task automatic test_inc_wrap();
    logic [W-1:0] v;
    load(1, 'hFF);
    do_op(1, OP_INC);
    peek(1, v);
    checks++;
    if (v !== 8'h00 || bus.z !== 1'b1 || bus.cy !== 1'b1) begin
      errors++;
      $display("FAIL inc_wrap: got %h z=%b cy=%b exp 00 1 1", v, bus.z, bus.cy);
    end
    do_op(1, OP_INC);
    peek(1, v);
    checks++;
    if (v !== 8'h01 || bus.z !== 1'b0 || bus.cy !== 1'b0) begin
      errors++;
      $display("FAIL inc_next: got %h z=%b cy=%b exp 01 0 0", v, bus.z, bus.cy);
    end
  endtask

  task automatic test_dec_borrow();
    logic [W-1:0] v;
    load(0, 'h00);
    do_op(0, OP_DEC);
    peek(0, v);
    checks++;
    if (v !== 8'hFF || bus.z !== 1'b0 || bus.cy !== 1'b1) begin
      errors++;
      $display("FAIL dec_borrow: got %h z=%b cy=%b exp ff 0 1", v, bus.z, bus.cy);
    end
    load(0, 'h01);
    checks++;
    if (bus.cy !== 1'b1) begin
      errors++;
      $display("FAIL load_keeps_cy: got %b exp 1", bus.cy);
    end
    do_op(0, OP_DEC);
    peek(0, v);
    checks++;
    if (v !== 8'h00 || bus.z !== 1'b1 || bus.cy !== 1'b0) begin
      errors++;
      $display("FAIL dec_zero: got %h z=%b cy=%b exp 00 1 0", v, bus.z, bus.cy);
    end
  endtask

  task automatic test_move_priority();
    logic [W-1:0] v0, v3;
    load(3, 'h20);
    load(0, 'h55);
    @(negedge clk);
    bus.E    = 1'b1;
    bus.rsel = 2'd3;
    bus.nL   = 1'b0;
    bus.wsel = 2'd0;
    bus.op_v = 1'b1;
    bus.op   = OP_INC;
    clock_edge();
    set_idle();
    peek(0, v0);
    peek(3, v3);
    checks++;
    if (v0 !== 8'h20 || v3 !== 8'h20 || bus.z !== 1'b0) begin
      errors++;
      $display("FAIL move: got r0=%h r3=%h z=%b exp 20 20 0", v0, v3, bus.z);
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] v;
    bit zb, cyb;
    load(1, 'h81);
    zb  = m_z;
    cyb = m_cy;
    do_op(1, OP_SHL);
    peek(1, v);
    checks++;
`ifdef WBUS_REG_SHIFT_EN
    if (v !== 8'h02 || bus.cy !== 1'b1 || bus.z !== 1'b0) begin
      errors++;
      $display("FAIL shl: got %h cy=%b z=%b exp 02 1 0", v, bus.cy, bus.z);
    end
`else
    if (v !== 8'h81 || bus.cy !== cyb || bus.z !== zb) begin
      errors++;
      $display("FAIL shl_nop: got %h cy=%b z=%b exp 81 %b %b", v, bus.cy, bus.z, cyb, zb);
    end
`endif
    do_op(1, OP_SHR);
    peek(1, v);
    checks++;
`ifdef WBUS_REG_SHIFT_EN
    if (v !== 8'h01 || bus.cy !== 1'b0 || bus.z !== 1'b0) begin
      errors++;
      $display("FAIL shr: got %h cy=%b z=%b exp 01 0 0", v, bus.cy, bus.z);
    end
`else
    if (v !== 8'h81 || bus.cy !== cyb || bus.z !== zb) begin
      errors++;
      $display("FAIL shr_nop: got %h cy=%b z=%b exp 81 %b %b", v, bus.cy, bus.z, cyb, zb);
    end
`endif
  endtask

  task automatic test_clr_reserved();
    logic [W-1:0] v;
    load(2, 'h7E);
    do_op(2, 3'd6);
    peek(2, v);
    checks++;
    if (v !== 8'h7E || bus.z !== 1'b0) begin
      errors++;
      $display("FAIL reserved_op: got %h z=%b exp 7e 0", v, bus.z);
    end
    do_op(2, OP_CLR);
    peek(2, v);
    checks++;
    if (v !== 8'h00 || bus.z !== 1'b1 || bus.cy !== 1'b0) begin
      errors++;
      $display("FAIL clr: got %h z=%b cy=%b exp 00 1 0", v, bus.z, bus.cy);
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] v;
    load(2, 'h33);
    load(1, 'hFF);
    @(negedge clk);
    bus.wsel = 2'd2;
    bus.op   = OP_INC;
    bus.op_v = 1'b1;
    #3 nclr = 1'b0;
    #1;
    model_reset();
    peek(2, v);
    checks++;
    if (v !== '0 || bus.z !== 1'b0 || bus.cy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got %h z=%b cy=%b exp 00 0 0", v, bus.z, bus.cy);
    end
    @(posedge clk);
    #1;
    peek(2, v);
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h exp 00", v);
    end
    @(negedge clk);
    nclr = 1'b1;
    set_idle();
    do_op(2, OP_INC);
    peek(2, v);
    checks++;
    if (v !== 8'h01 || bus.z !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_op: got %h z=%b exp 01 0", v, bus.z);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] v;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.nL   = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      bus.E    = 1'($urandom_range(0, 1));
      bus.wsel = 2'($urandom_range(0, N - 1));
      bus.rsel = 2'($urandom_range(0, N - 1));
      bus.op   = 3'($urandom_range(0, 7));
      bus.op_v = 1'($urandom_range(0, 1));
      drv      = W'($urandom);
      drv_en   = !bus.E;
      clock_edge();
      checks++;
      if (bus.z !== m_z || bus.cy !== m_cy) begin
        errors++;
        $display("FAIL rnd_flags[%0d]: got z=%b cy=%b exp %b %b", n, bus.z, bus.cy, m_z, m_cy);
      end
      if (bus.E) begin
        checks++;
        if (WBUS !== W'(m_reg[int'(bus.rsel)])) begin
          errors++;
          $display("FAIL rnd_bus[%0d]: got %h exp %h", n, WBUS, W'(m_reg[int'(bus.rsel)]));
        end
      end
      for (int i = 0; i < N; i++) begin
        peek(i, v);
        checks++;
        if (v !== W'(m_reg[i])) begin
          errors++;
          $display("FAIL rnd_reg%0d[%0d]: got %h exp %h", i, n, v, W'(m_reg[i]));
        end
      end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    model_reset();
    test_reset();
    test_load_bus();
    test_inc_wrap();
    test_dec_borrow();
    test_move_priority();
    test_shift();
    test_clr_reserved();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
